// File: rtl/seg_decode.sv
// ============================================================================
// Module   : seg_decode
// Purpose  : Recovers a hex nibble from a stable 7-segment pattern and reports
//            each distinct stable pattern once. Optional macro SEG_BLANK_EN
//            accepts the all-off pattern as a legal blank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_decode #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    output logic       o_vld,
    output logic [3:0] o_hex,
    output logic       o_err,
    output logic       o_blank,
    output logic [7:0] o_err_cnt
);

    localparam logic [7:0] C_LAST_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_TRACK = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_seg_q;
    logic [6:0] r_cand, w_cand_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [6:0] r_last;
    logic       r_have_last;
    logic       w_done;
    logic       w_report;
    logic [3:0] w_hex;
    logic       w_err;
`ifdef SEG_BLANK_EN
    logic       w_blank;
`endif

    always_comb begin
        w_hex = 4'h0;
        w_err = 1'b0;
        case (r_cand)
            7'h7E: w_hex = 4'h0;
            7'h30: w_hex = 4'h1;
            7'h6D: w_hex = 4'h2;
            7'h79: w_hex = 4'h3;
            7'h33: w_hex = 4'h4;
            7'h5B: w_hex = 4'h5;
            7'h5F: w_hex = 4'h6;
            7'h70: w_hex = 4'h7;
            7'h7F: w_hex = 4'h8;
            7'h7B: w_hex = 4'h9;
            7'h77: w_hex = 4'hA;
            7'h1F: w_hex = 4'hB;
            7'h4E: w_hex = 4'hC;
            7'h3D: w_hex = 4'hD;
            7'h4F: w_hex = 4'hE;
            7'h47: w_hex = 4'hF;
            default: w_err = 1'b1;
        endcase
`ifdef SEG_BLANK_EN
        w_blank = 1'b0;
        if (r_cand == 7'h00) begin
            w_err   = 1'b0;
            w_blank = 1'b1;
        end
`endif
    end

    // A mismatch always wins over a completing count, so a change on the
    // completion edge cancels the report.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_report    = 1'b0;
        if (r_seg_q != r_cand) begin
            w_cand_nxt  = r_seg_q;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_TRACK;
        end else if (r_state == S_TRACK) begin
            if (r_cnt == C_LAST_CNT) begin
                w_state_nxt = S_HOLD;
                w_done      = 1'b1;
                w_report    = !r_have_last || (r_cand != r_last);
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_TRACK;
            r_seg_q     <= 7'h00;
            r_cand      <= 7'h00;
            r_cnt       <= 8'd0;
            r_last      <= 7'h00;
            r_have_last <= 1'b0;
            o_vld       <= 1'b0;
            o_hex       <= 4'h0;
            o_err       <= 1'b0;
            o_err_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_seg_q <= i_seg;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            o_vld   <= w_report;
            if (w_done) begin
                r_last      <= r_cand;
                r_have_last <= 1'b1;
            end
            if (w_report) begin
                o_hex <= w_hex;
                o_err <= w_err;
                if (w_err && (o_err_cnt != 8'hFF))
                    o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

`ifdef SEG_BLANK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_blank <= 1'b0;
        else if (w_report)
            o_blank <= w_blank;
    end
`else
    assign o_blank = 1'b0;
`endif

endmodule

`default_nettype wire
